// File: rtl/chacha20_xor_stream.sv
// chacha20_xor_stream
//   Byte-stream encryptor that sits downstream of chacha20core. It requests
//   512-bit keystream blocks from the core, captures each block on the core's
//   ready pulse, and XORs plaintext bytes with keystream bytes to produce
//   ciphertext. The nonce advances by NONCE_STEP after every captured block,
//   so keystream is never reused.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   nonce_load, nonce_seed start a session with the given first nonce (IDLE only)
//   core_enable            one-cycle request pulse to the core
//   core_nonce             nonce presented to the core, stable until the block is captured
//   core_cipher, core_ready keystream block and its one-cycle valid pulse
//   in_data/in_valid/in_last/in_ready     plaintext byte stream
//   out_data/out_valid/out_last/out_ready ciphertext byte stream
//   blk_count              blocks captured since reset (wraps)
//   err                    sticky core-timeout flag, cleared only by reset
//   fsm_state              debug view of the controller state
//
// Handshakes (both byte streams): a byte transfers on a rising clock edge
// where valid && ready. The producer holds valid and data stable until that
// edge. out_valid/out_data/out_last form a one-deep register that refills in
// the same cycle it drains, so full rate needs no bubble.
module chacha20_xor_stream #(
  parameter int          WAIT_TIMEOUT = 64,
  parameter logic [95:0] NONCE_STEP   = 96'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         nonce_load,
  input  logic [95:0]  nonce_seed,
  output logic         core_enable,
  output logic [95:0]  core_nonce,
  input  logic [511:0] core_cipher,
  input  logic         core_ready,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic [31:0]  blk_count,
  output logic         err,
  output logic [1:0]   fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TIMEOUT - 1);

  logic [1:0]    state;
  logic [511:0]  ks;
  logic [5:0]    idx;
  logic [TW-1:0] wait_cnt;
  logic          accept;
  logic [8:0]    ks_lsb;
  logic [7:0]    ks_byte;

  assign fsm_state   = state;
  assign core_enable = (state == S_REQ);
  // A byte is taken only while streaming, and only if the output register is
  // empty or draining this same cycle.
  assign in_ready    = (state == S_STREAM) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;

  // Little-endian words: idx = 4w+b selects ks[480-32w+8b +: 8].
  always_comb begin
    ks_lsb  = 9'd480 - {idx[5:2], 5'd0} + {4'd0, idx[1:0], 3'd0};
    ks_byte = ks[ks_lsb +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      ks         <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      core_nonce <= '0;
      blk_count  <= '0;
      err        <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      // Output register drains in any state; a new byte can only arrive in STREAM.
      if (accept) begin
        out_data  <= in_data ^ ks_byte;
        out_last  <= in_last;
        out_valid <= 1'b1;
        idx       <= idx + 6'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (nonce_load) begin
            core_nonce <= nonce_seed;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A ready pulse on the final timeout cycle still wins.
          if (core_ready) begin
            ks         <= core_cipher;
            idx        <= '0;
            core_nonce <= core_nonce + NONCE_STEP;
            blk_count  <= blk_count + 32'd1;
            state      <= S_STREAM;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_STREAM: begin
          // End of block or end of message: fetch a fresh block, dropping any
          // unused keystream so every message starts at byte 0 of a new block.
          if (accept && (idx == 6'd63 || in_last)) begin
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_xor_stream.sv
`timescale 1ns/1ps
module tb_chacha20_xor_stream;

  // Debug codes reported on fsm_state
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         nonce_load = 1'b0;
  logic [95:0]  nonce_seed = '0;
  logic         core_enable;
  logic [95:0]  core_nonce;
  logic [511:0] core_cipher = '0;
  logic         core_ready = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic [31:0]  blk_count;
  logic         err;
  logic [1:0]   fsm_state;

  chacha20_xor_stream dut (
    .clk(clk), .resetn(resetn), .nonce_load(nonce_load), .nonce_seed(nonce_seed),
    .core_enable(core_enable), .core_nonce(core_nonce), .core_cipher(core_cipher),
    .core_ready(core_ready), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .blk_count(blk_count), .err(err), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0]   exp_q[$];       // {last, cipher byte}
  logic [511:0] blocks[$];      // every block the core model delivered, in order
  logic [95:0]  req_nonces[$];  // nonce seen on each request since reset
  int n_enables = 0;
  int next_blk = 0;
  int cur_blk = 0;
  int pos = 0;
  bit core_mute = 1'b0;
  int stray_req = 0;
  int stray_done = 0;
  int pend = 0;
  bit bp_on = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Keystream byte i of a block: word i/4 counted from the top, little-endian bytes.
  function automatic logic [7:0] ks_ref(input logic [511:0] blk, input int i);
    logic [511:0] t;
    logic [31:0]  w;
    t = blk >> (480 - 32 * (i / 4));
    w = t[31:0];
    w = w >> (8 * (i % 4));
    return w[7:0];
  endfunction

  // ---------------- core model ----------------
  always @(negedge clk) begin
    core_ready = 1'b0;
    if (!resetn) begin
      pend = 0;
      n_enables = 0;
      req_nonces.delete();
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_cipher = rand512();
          blocks.push_back(core_cipher);
          core_ready = 1'b1;
        end
      end else if (stray_req != stray_done) begin
        stray_done = stray_req;
        core_cipher = rand512();
        core_ready = 1'b1;
      end
      if (core_enable) begin
        n_enables++;
        req_nonces.push_back(core_nonce);
        if (!core_mute) pend = $urandom_range(1, 4);
      end
    end
  end

  // ---------------- output scoreboard ----------------
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL out_extra observed=%0h expected=none", {out_last, out_data});
      end else begin
        check("out_byte", {out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    nonce_load = 1'b0;
    out_ready = 1'b1;
    core_mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
    next_blk = blocks.size();
    pos = 0;
  endtask

  task automatic load_nonce(input logic [95:0] s);
    nonce_seed = s;
    nonce_load = 1'b1;
    @(posedge clk);
    #1;
    nonce_load = 1'b0;
  endtask

  task automatic msg_begin();
    cur_blk = next_blk;
    next_blk++;
    pos = 0;
  endtask

  task automatic send_data(input logic [7:0] d, input bit last);
    bit acc;
    if (pos == 64) begin
      cur_blk = next_blk;
      next_blk++;
      pos = 0;
    end
    in_data = d;
    in_last = last;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!acc) begin
      fail_now("send_timeout");
    end else if (cur_blk >= blocks.size()) begin
      fail_now("no_block");
    end else begin
      exp_q.push_back({last, d ^ ks_ref(blocks[cur_blk], pos)});
    end
    pos++;
  endtask

  task automatic send_msg(input int n, input bit zero);
    msg_begin();
    for (int i = 0; i < n; i++) send_data(zero ? 8'h00 : 8'($urandom), i == n - 1);
  endtask

  task automatic wait_state(input logic [1:0] st, input string tag);
    for (int k = 0; k < 200; k++) begin
      if (fsm_state == st) break;
      @(posedge clk);
      #1;
    end
    check(tag, fsm_state, st);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [95:0] seed;
    logic [8:0]  held;
    time         t0;

    // Test 1: reset values, one full block of zero plaintext
    apply_reset();
    check("rst_core_enable", core_enable, 0);
    check("rst_core_nonce", core_nonce, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_blk_count", blk_count, 0);
    check("rst_err", err, 0);
    check("rst_state", fsm_state, ST_IDLE);
    load_nonce(96'h1);
    msg_begin();
    send_data(8'h00, 1'b0);
    check("t1_nonce_after_capture", core_nonce, 96'h2);
    check("t1_blk_count", blk_count, 1);
    check("t1_enables", n_enables, 1);
    check("t1_req_nonce", req_nonces[0], 96'h1);
    for (int i = 1; i < 64; i++) send_data(8'h00, i == 63);
    check("t1_state_req", fsm_state, ST_REQ);
    check("t1_enables_end", n_enables, 1);
    drain("t1_drain");

    // Test 2: 70-byte message spans two blocks, random backpressure
    apply_reset();
    seed = rand96();
    load_nonce(seed);
    bp_on = 1'b1;
    fork
      begin
        send_msg(70, 1'b0);
        check("t2_state_req", fsm_state, ST_REQ);
        check("t2_blk_count", blk_count, 2);
        check("t2_enables", n_enables, 2);
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    check("t2_req_nonce0", req_nonces[0], seed);
    check("t2_req_nonce1", req_nonces[1], seed + 96'd1);
    drain("t2_drain");

    // Test 3: two short messages, each on a fresh block; nonce wraps
    apply_reset();
    seed = '1;
    load_nonce(seed);
    send_msg(3, 1'b0);
    wait_state(ST_STREAM, "t3_stream");
    check("t3_nonce_plus2", core_nonce, 96'h1);
    load_nonce(rand96());
    check("t3_load_ignored_nonce", core_nonce, 96'h1);
    check("t3_load_ignored_state", fsm_state, ST_STREAM);
    send_msg(3, 1'b0);
    check("t3_req_nonce0", req_nonces[0], seed);
    check("t3_req_nonce1_wrap", req_nonces[1], 96'h0);
    check("t3_blk_count", blk_count, 2);
    drain("t3_drain");

    // Test 4: 10-cycle stall mid-stream, then full rate
    wait_state(ST_STREAM, "t4_stream");
    msg_begin();
    for (int i = 0; i < 10; i++) send_data(8'($urandom), 1'b0);
    out_ready = 1'b0;
    in_data = 8'($urandom);
    in_valid = 1'b1;
    check("t4_pending", exp_q.size(), 1);
    held = (exp_q.size() > 0) ? exp_q[0] : 9'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_data", {out_last, out_data}, held);
      check("t4_stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 10; i++) send_data(8'($urandom), 1'b0);
    check("t4_full_rate", ($time - t0) / 10, 10);
    for (int i = 0; i < 20; i++) send_data(8'($urandom), i == 19);
    drain("t4_drain");

    // Test 5: core never answers -> timeout
    apply_reset();
    core_mute = 1'b1;
    load_nonce(rand96());
    wait_state(ST_WAIT, "t5_wait");
    in_valid = 1'b1;
    repeat (63) begin
      @(posedge clk);
      #1;
    end
    check("t5_still_wait", fsm_state, ST_WAIT);
    check("t5_err_before", err, 0);
    @(posedge clk);
    #1;
    check("t5_idle", fsm_state, ST_IDLE);
    check("t5_err", err, 1);
    check("t5_in_ready", in_ready, 0);
    in_valid = 1'b0;
    stray_req++;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t5_stray_blk", blk_count, 0);
    check("t5_stray_state", fsm_state, ST_IDLE);
    core_mute = 1'b0;
    next_blk = blocks.size();
    load_nonce(rand96());
    send_msg(5, 1'b0);
    check("t5_err_sticky", err, 1);
    check("t5_restart_blk", blk_count, 1);
    drain("t5_drain");

    // Test 6: asynchronous reset at idx 30
    apply_reset();
    load_nonce(rand96());
    msg_begin();
    for (int i = 0; i < 30; i++) send_data(8'($urandom), 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_core_enable", core_enable, 0);
    check("t6_core_nonce", core_nonce, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 0);
    check("t6_out_last", out_last, 0);
    check("t6_blk_count", blk_count, 0);
    check("t6_state", fsm_state, ST_IDLE);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    next_blk = blocks.size();
    @(posedge clk);
    #1;
    check("t6_idle_after", fsm_state, ST_IDLE);
    check("t6_in_ready_after", in_ready, 0);
    load_nonce(rand96());
    send_msg(8, 1'b0);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
